clk_gen_trim: RTL and testbench
===============================

Name: clk_gen_trim

Overview:
- Parametrised, trimmable successor to the fixed 32,768 Hz strobe divider.
- Converts an asynchronous reference clock into single-`i_clk`-cycle strobes: 1 Hz main tick, slow set tick, fast set tick.
- Adds a signed per-second period trim for crystal calibration and a synchronous phase clear (restart the second when time is set).
- Sits between the refclk input pin and the clock/time-set logic.

Parameters:
- DIV_WIDTH, 15: nominal refclk edges per second = 2^DIV_WIDTH.
- TRIM_WIDTH, 8: width of the signed trim input.
- SLOW_SHIFT, 1: slow strobe rate = 2^SLOW_SHIFT per nominal second (2 Hz).
- FAST_SHIFT, 3: fast strobe rate = 2^FAST_SHIFT per nominal second (8 Hz).
- SYNC_STAGES, 2: synchroniser depth for i_refclk (minimum 2); only used with the optional feature.

Ports:
- i_clk  in  1  system clock, at least 4x refclk frequency.
- i_reset_n  in  1  reset.
- i_refclk  in  1  reference clock (32,768 Hz nominal).
- i_trim  in  TRIM_WIDTH  signed period adjustment in refclk edges; |i_trim| < 2^(DIV_WIDTH-1).
- i_clear  in  1  synchronous phase clear.
- o_1hz_stb  out  1  one-cycle strobe once per trimmed second.
- o_slow_set_stb  out  1  one-cycle slow set strobe.
- o_fast_set_stb  out  1  one-cycle fast set strobe.
- o_trim_active  out  TRIM_WIDTH  trim value governing the current second.

Behaviour:
- Reset and clock (decided): reset i_reset_n, synchronous, active-low; clock i_clk.
- Reset state:
  - cnt (DIV_WIDTH+1 bits) = 0; trim_active = 0.
  - Synchroniser and edge-history registers = 0.
  - All strobe outputs = 0.
- Edge detect:
  - ref_stb = synchronised refclk AND NOT its one-cycle-delayed copy.
  - Exactly one `i_clk` cycle per refclk rising edge.
- Period: P = 2^DIV_WIDTH + sign-extended trim_active. nxt = cnt + 1.
- Each cycle, in priority order:
  1. i_clear = 1: cnt <= 0; no strobes next cycle; trim_active <= i_trim.
  2. Else ref_stb with nxt == P ("wrap"):
     - cnt <= 0; trim_active <= i_trim.
     - Next cycle: o_1hz_stb, o_slow_set_stb and o_fast_set_stb all = 1.
  3. Else ref_stb:
     - cnt <= nxt.
     - Next cycle: o_fast_set_stb = 1 if nxt[DIV_WIDTH-FAST_SHIFT-1:0] == 0.
     - Next cycle: o_slow_set_stb = 1 if nxt[DIV_WIDTH-SLOW_SHIFT-1:0] == 0.
  4. Else: hold cnt.
- Strobe outputs are registered and deassert the following cycle, so no output is high for 2 consecutive cycles.
- Latency: 1 cycle from ref_stb to strobe (plus synchroniser stages when the optional feature is enabled).
- Trim timing:
  - i_trim is sampled only at wrap or clear; mid-second changes take effect the next second.
  - With trim != 0 the final fast/slow sub-period of each second is shortened or lengthened.
  - With positive trim, a sub-period strobe at nxt = 2^DIV_WIDTH precedes the wrap strobe.
- i_clear together with ref_stb: the clear wins and the edge is discarded.
- Reset mid-second discards phase; the first 1 Hz strobe comes 2^DIV_WIDTH edges after release.

Optional Feature:
- Macro: CLK_GEN_TRIM_SYNC_EN.
- Defined: i_refclk passes through a SYNC_STAGES-deep flop chain (reset to 0) before edge detect, so strobe latency = SYNC_STAGES+1 cycles from the pin edge.
- Undefined: i_refclk must already be synchronous to i_clk and feeds edge detect directly (latency 1 cycle); SYNC_STAGES is ignored.

Test Plan:
All tests use DIV_WIDTH=4, SLOW_SHIFT=1, FAST_SHIFT=3, refclk period 8 `i_clk` cycles.
1. Trim 0, 48 refclk edges:
   - o_1hz_stb exactly 3 times, every 16 edges.
   - o_slow_set_stb every 8 edges.
   - o_fast_set_stb every 2 edges.
   - Each strobe 1 cycle wide.
2. i_trim = +2 from reset:
   - First second is 16 edges (trim_active = 0).
   - Next second is 18 edges.
   - Fast strobes at nxt = 2,4,...,16 then again at wrap (edge 18).
   - o_trim_active = 2 after the first wrap.
3. i_trim = -3:
   - Seconds of 13 edges after the first wrap.
   - Slow strobe at nxt = 8 and at wrap only.
4. i_clear pulsed coinciding with ref_stb at cnt = 9:
   - No strobe that cycle.
   - cnt = 0.
   - Next 1 Hz strobe exactly 16 edges later.
5. Reset asserted mid-second at cnt = 11:
   - All outputs 0, o_trim_active = 0.
   - First o_1hz_stb on the 16th edge after release.
6. i_refclk held high for 100 cycles then low: exactly one edge counted, no repeated strobes. With CLK_GEN_TRIM_SYNC_EN, strobe appears SYNC_STAGES+1 cycles after the pin edge.

Source files
------------

// File: rtl/clk_gen_trim_if.sv
// rtl/clk_gen_trim_if.sv - refclk/trim/clear inputs and strobe outputs of clk_gen_trim
interface clk_gen_trim_if #(
  parameter int TRIM_WIDTH = 8
);
  logic                  i_refclk;
  logic [TRIM_WIDTH-1:0] i_trim;
  logic                  i_clear;
  logic                  o_1hz_stb;
  logic                  o_slow_set_stb;
  logic                  o_fast_set_stb;
  logic [TRIM_WIDTH-1:0] o_trim_active;

  modport master (
    output i_refclk, i_trim, i_clear,
    input  o_1hz_stb, o_slow_set_stb, o_fast_set_stb, o_trim_active
  );

  modport slave (
    input  i_refclk, i_trim, i_clear,
    output o_1hz_stb, o_slow_set_stb, o_fast_set_stb, o_trim_active
  );
endinterface

// File: rtl/clk_gen_trim.sv
// rtl/clk_gen_trim.sv - trimmable refclk divider producing 1 Hz, slow and fast set strobes
// Define CLK_GEN_TRIM_SYNC_EN to pass i_refclk through a SYNC_STAGES-deep synchroniser.
module clk_gen_trim #(
  parameter int DIV_WIDTH   = 15,
  parameter int TRIM_WIDTH  = 8,
  parameter int SLOW_SHIFT  = 1,
  parameter int FAST_SHIFT  = 3,
  parameter int SYNC_STAGES = 2
) (
  input logic           i_clk,
  input logic           i_reset_n,
  clk_gen_trim_if.slave bus
);
  localparam int CW = DIV_WIDTH + 1;
  localparam int PW = ((CW > TRIM_WIDTH) ? CW : TRIM_WIDTH) + 1;

  logic                  ref_sync;
  logic                  ref_stb;
  logic                  ref_prev_q, ref_prev_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         nxt;
  logic [PW-1:0]         period;
  logic [TRIM_WIDTH-1:0] trim_active_q, trim_active_d;
  logic                  stb_1hz_q, stb_1hz_d;
  logic                  slow_stb_q, slow_stb_d;
  logic                  fast_stb_q, fast_stb_d;

`ifdef CLK_GEN_TRIM_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.i_refclk};
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign ref_sync = sync_q[SYNC_STAGES-1];
`else
  logic unused_sync_stages;
  assign unused_sync_stages = (SYNC_STAGES > 0);
  assign ref_sync = bus.i_refclk;
`endif

  always_comb begin
    ref_prev_d    = ref_sync;
    ref_stb       = ref_sync & ~ref_prev_q;
    nxt           = cnt_q + CW'(1);
    // Trim is sign-extended into a width that holds 2^DIV_WIDTH plus any legal trim
    period        = (PW'(1) << DIV_WIDTH)
                  + {{(PW-TRIM_WIDTH){trim_active_q[TRIM_WIDTH-1]}}, trim_active_q};
    cnt_d         = cnt_q;
    trim_active_d = trim_active_q;
    stb_1hz_d     = 1'b0;
    slow_stb_d    = 1'b0;
    fast_stb_d    = 1'b0;
    if (bus.i_clear) begin
      cnt_d         = '0;
      trim_active_d = bus.i_trim;
    end else if (ref_stb && ({{(PW-CW){1'b0}}, nxt} == period)) begin
      cnt_d         = '0;
      trim_active_d = bus.i_trim;
      stb_1hz_d     = 1'b1;
      slow_stb_d    = 1'b1;
      fast_stb_d    = 1'b1;
    end else if (ref_stb) begin
      cnt_d      = nxt;
      fast_stb_d = (nxt[DIV_WIDTH-FAST_SHIFT-1:0] == '0);
      slow_stb_d = (nxt[DIV_WIDTH-SLOW_SHIFT-1:0] == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ref_prev_q    <= 1'b0;
      cnt_q         <= '0;
      trim_active_q <= '0;
      stb_1hz_q     <= 1'b0;
      slow_stb_q    <= 1'b0;
      fast_stb_q    <= 1'b0;
    end else begin
      ref_prev_q    <= ref_prev_d;
      cnt_q         <= cnt_d;
      trim_active_q <= trim_active_d;
      stb_1hz_q     <= stb_1hz_d;
      slow_stb_q    <= slow_stb_d;
      fast_stb_q    <= fast_stb_d;
    end
  end

  assign bus.o_1hz_stb      = stb_1hz_q;
  assign bus.o_slow_set_stb = slow_stb_q;
  assign bus.o_fast_set_stb = fast_stb_q;
  assign bus.o_trim_active  = trim_active_q;
endmodule

// File: tb/tb_clk_gen_trim.sv
// tb/tb_clk_gen_trim.sv - directed self-checking bench for clk_gen_trim (DIV_WIDTH=4)
module tb_clk_gen_trim;
  localparam int DW = 4;
  localparam int TW = 8;
  localparam int SS = 2;
`ifdef CLK_GEN_TRIM_SYNC_EN
  localparam int LAT = SS + 1;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  clk_gen_trim_if #(.TRIM_WIDTH(TW)) bus ();

  clk_gen_trim #(
    .DIV_WIDTH  (DW),
    .TRIM_WIDTH (TW),
    .SLOW_SHIFT (1),
    .FAST_SHIFT (3),
    .SYNC_STAGES(SS)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int wide_cnt = 0;
  logic [2:0] prev_s = '0;
  logic [2:0] edge_s [0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // {1hz, slow, fast}; a strobe seen on two consecutive samples counts as too wide
  task automatic sample(output logic [2:0] s);
    s = {bus.o_1hz_stb, bus.o_slow_set_stb, bus.o_fast_set_stb};
    if ((s & prev_s) != 3'b000) wide_cnt++;
    prev_s = s;
  endtask

  task automatic ref_period(input int k, input bit clr);
    logic [2:0] s;
    logic [2:0] acc;
    acc = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      sample(s);
      acc |= s;
      bus.i_refclk = (c < 4);
      if (clr) bus.i_clear = (c == LAT - 1);
    end
    edge_s[k] = acc;
  endtask

  task automatic run(input int n, input int start);
    for (int k = 0; k < n; k++) ref_period(start + k, 1'b0);
  endtask

  function automatic logic [2:0] exp_pat(input int j, input int p);
    if (j == p) return 3'b111;
    return {1'b0, (j % 8) == 0, (j % 2) == 0};
  endfunction

  task automatic check_seconds(input string tag, input int n, input int p_first, input int p_rest);
    int j;
    int p;
    j = 1;
    p = p_first;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_edge%0d", tag, k + 1), {29'd0, edge_s[k]}, {29'd0, exp_pat(j, p)});
      if (j == p) begin
        j = 1;
        p = p_rest;
      end else begin
        j++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_refclk = 1'b0;
    bus.i_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_s = '0;
  endtask

  initial begin
    logic [2:0] s;
    int hits;
    int first_at;
    logic [2:0] first_s;

    bus.i_refclk = 1'b0;
    bus.i_trim = '0;
    bus.i_clear = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_1hz", {31'd0, bus.o_1hz_stb}, 32'd0);
    chk("rst_slow", {31'd0, bus.o_slow_set_stb}, 32'd0);
    chk("rst_fast", {31'd0, bus.o_fast_set_stb}, 32'd0);
    chk("rst_trim_active", {24'd0, bus.o_trim_active}, 32'd0);
    chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
    rst_n = 1'b1;

    // Trim 0: 48 edges, three full seconds
    run(48, 0);
    check_seconds("t1", 48, 16, 16);
    chk("t1_width", wide_cnt, 32'd0);

    // Trim +2: first second still 16 edges, then 18
    bus.i_trim = 8'h02;
    do_reset();
    run(16, 0);
    chk("t2_trim_active", {24'd0, bus.o_trim_active}, 32'h02);
    run(18, 16);
    check_seconds("t2", 34, 16, 18);

    // Trim -3: seconds of 13 after the first wrap
    bus.i_trim = 8'hFD;
    do_reset();
    run(42, 0);
    check_seconds("t3", 42, 16, 13);
    chk("t3_trim_active", {24'd0, bus.o_trim_active}, 32'hFD);

    // Reset mid-second at cnt 11 discards phase and trim
    run(11, 0);
    chk("t5_cnt_before", 32'(dut.cnt_q), 32'd11);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_rst_outs", {29'd0, bus.o_1hz_stb, bus.o_slow_set_stb, bus.o_fast_set_stb}, 32'd0);
    chk("t5_rst_trim_active", {24'd0, bus.o_trim_active}, 32'd0);
    chk("t5_rst_cnt", 32'(dut.cnt_q), 32'd0);
    rst_n = 1'b1;
    prev_s = '0;
    run(16, 0);
    check_seconds("t5", 16, 16, 13);

    // Clear coinciding with the edge at cnt 9
    bus.i_trim = 8'h00;
    do_reset();
    run(9, 0);
    chk("t4_cnt_before", 32'(dut.cnt_q), 32'd9);
    ref_period(9, 1'b1);
    chk("t4_clear_stb", {29'd0, edge_s[9]}, 32'd0);
    chk("t4_clear_cnt", 32'(dut.cnt_q), 32'd0);
    run(16, 0);
    check_seconds("t4", 16, 16, 16);

    // refclk held high 100 cycles: one edge, one strobe, at the expected latency
    do_reset();
    run(1, 0);
    hits = 0;
    first_at = -1;
    first_s = '0;
    @(negedge clk);
    bus.i_refclk = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      sample(s);
      if (s != 3'b000) begin
        hits++;
        if (first_at < 0) begin
          first_at = i;
          first_s = s;
        end
      end
    end
    bus.i_refclk = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sample(s);
      if (s != 3'b000) hits++;
    end
    chk("t6_hits", hits, 32'd1);
    chk("t6_latency", first_at, LAT);
    chk("t6_strobe", {29'd0, first_s}, 32'd1);
    chk("t6_cnt", 32'(dut.cnt_q), 32'd2);
    chk("all_width", wide_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
